// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver with a valid/ack output buffer, framing-error and overrun pulses.
module uart_rx #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 115_200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data,
   output logic       data_valid,
   input  logic       data_ack,
   output logic       rx_busy,
   output logic       frame_err,
   output logic       overrun
);
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);

   if (CLKS_PER_BIT < 4) begin : g_bad_rate
      $error("uart_rx: CLKS_PER_BIT must be at least 4");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             fe_q, fe_d;
   logic             ov_q, ov_d;
   logic             rx_meta_q, rx_s_q;
   logic             bit_end, done;

   assign bit_end = cnt_q == BIT_END;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      idx_d   = idx_q;
      shreg_d = shreg_q;
      fe_d    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s_q) state_d = START;
         end
         START: if (cnt_q == HALF_END) begin
            cnt_d   = '0;
            idx_d   = 3'd0;
            state_d = rx_s_q ? IDLE : DATA;
         end
         DATA: if (bit_end) begin
            cnt_d          = '0;
            shreg_d[idx_q] = rx_s_q;
            idx_d          = idx_q + 3'd1;
            if (idx_q == 3'd7) state_d = STOP;
         end
         STOP: if (bit_end) begin
            cnt_d   = '0;
            done    = rx_s_q;
            fe_d    = !rx_s_q;
            state_d = rx_s_q ? IDLE : BREAK;
         end
         BREAK: begin
            cnt_d = '0;
            if (rx_s_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // an ack on the completion edge frees the buffer for the new byte
      data_d  = (done && (!valid_q || data_ack)) ? shreg_q : data_q;
      valid_d = done || (valid_q && !data_ack);
      ov_d    = done && valid_q && !data_ack;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= 3'd0;
         shreg_q   <= 8'h00;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         fe_q      <= 1'b0;
         ov_q      <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shreg_q   <= shreg_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         fe_q      <= fe_d;
         ov_q      <= ov_d;
      end
   end

   assign data       = data_q;
   assign data_valid = valid_q;
   assign rx_busy    = state_q != IDLE;
   assign frame_err  = fe_q;
   assign overrun    = ov_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized scoreboard bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;
   localparam int CPB  = 16;
   localparam int HALF = 8;

   logic       clk = 1'b0;
   logic       rst_n, rx, data_ack, ack_auto, ack_man, auto_en;
   logic [7:0] data;
   logic       data_valid, rx_busy, frame_err, overrun;
   int         cyc = 0;
   int         n_chk = 0, n_pass = 0;
   int         fe_cnt = 0, ov_cnt = 0, exp_fe = 0, exp_ov = 0;
   int         pres_cyc = -1;
   logic [7:0] exp_q[$];

   assign data_ack = ack_auto | ack_man;

   uart_rx #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx), .data(data), .data_valid(data_valid),
      .data_ack(data_ack), .rx_busy(rx_busy), .frame_err(frame_err), .overrun(overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Byte the receiver should assemble when each line bit lasts n clocks:
   // data bit i is read from line bit (HALF + CPB*(i+1)) / n after the start edge.
   function automatic logic [7:0] exp_byte(input logic [7:0] b, input int n);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         int j;
         j = (HALF + CPB * (i + 1)) / n;
         r[i] = (j == 0) ? 1'b0 : (j <= 8) ? b[j-1] : 1'b1;
      end
      return r;
   endfunction

   task automatic send_byte(input logic [7:0] b, input int n, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = f[i];
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int k);
      rx = 1'b1;
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic ack_pulse;
      ack_man = 1'b1;
      @(posedge clk);
      #1 ack_man = 1'b0;
   endtask

   // monitor: a byte is presented when valid rises or survives an ack edge
   initial begin
      logic prev_v, prev_a, prev_fe, prev_ov;
      prev_v = 0; prev_a = 0; prev_fe = 0; prev_ov = 0;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            if (data_valid && (!prev_v || prev_a)) begin
               pres_cyc = cyc;
               if (exp_q.size() == 0) begin
                  n_chk++;
                  $display("FAIL unexpected_byte: got %02h, none expected (cycle %0d)", data, cyc);
               end else chk("byte", {24'h0, data}, {24'h0, exp_q.pop_front()});
            end
            if (frame_err) begin fe_cnt++; chk("frame_err_width", {31'h0, prev_fe}, 0); end
            if (overrun) begin ov_cnt++; chk("overrun_width", {31'h0, prev_ov}, 0); end
         end
         prev_v = data_valid; prev_a = data_ack; prev_fe = frame_err; prev_ov = overrun;
      end
   end

   initial begin
      int wt, dly;
      wt = 0; dly = 0; ack_auto = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (ack_auto) begin
            ack_auto = 1'b0;
            wt = 0;
            dly = $urandom_range(0, 10);
         end else if (auto_en && data_valid) begin
            if (wt >= dly) ack_auto = 1'b1;
            else wt++;
         end else wt = 0;
      end
   end

   initial begin
      int c0;
      logic [7:0] b;
      logic [7:0] seq[4] = '{8'h00, 8'hFF, 8'hA5, 8'h5A};
      rst_n = 1'b0; rx = 1'b1; ack_man = 1'b0; auto_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", {24'h0, data}, 0);
      chk("rst_valid", {31'h0, data_valid}, 0);
      chk("rst_busy", {31'h0, rx_busy}, 0);
      chk("rst_frame_err", {31'h0, frame_err}, 0);
      chk("rst_overrun", {31'h0, overrun}, 0);
      rst_n = 1'b1;
      idle(8);

      // single byte, latency and hold-until-ack
      c0 = cyc;
      exp_q.push_back(8'h2B);
      send_byte(8'h2B, CPB, 1'b1);
      chk("latency", pres_cyc - c0, 155);
      idle(10);
      chk("hold_valid", {31'h0, data_valid}, 1);
      chk("hold_data", {24'h0, data}, 8'h2B);
      ack_pulse();
      chk("ack_clears", {31'h0, data_valid}, 0);
      idle(8);

      // back-to-back frames
      auto_en = 1'b1;
      foreach (seq[i]) begin
         exp_q.push_back(seq[i]);
         send_byte(seq[i], CPB, 1'b1);
      end
      idle(32);
      chk("b2b_drained", exp_q.size(), 0);
      chk("b2b_overrun", ov_cnt, exp_ov);

      // glitch
      c0 = cyc;
      rx = 1'b0;
      repeat (4) @(posedge clk);
      #1 rx = 1'b1;
      repeat (c0 + 10 - cyc) @(posedge clk);
      #1 chk("glitch_busy_hi", {31'h0, rx_busy}, 1);
      @(posedge clk);
      #1 chk("glitch_busy_lo", {31'h0, rx_busy}, 0);
      idle(32);

      // framing error followed by a long break
      send_byte(8'h41, CPB, 1'b0);
      exp_fe++;
      repeat (40 * CPB) @(posedge clk);
      #1;
      idle(32);
      chk("break_frame_err", fe_cnt, exp_fe);
      exp_q.push_back(8'h42);
      send_byte(8'h42, CPB, 1'b1);
      idle(32);

      // overrun: second byte dropped without ack
      auto_en = 1'b0;
      idle(4);
      exp_q.push_back(8'h11);
      send_byte(8'h11, CPB, 1'b1);
      send_byte(8'h22, CPB, 1'b1);
      exp_ov++;
      chk("ovr_count", ov_cnt, exp_ov);
      chk("ovr_keep_data", {24'h0, data}, 8'h11);
      chk("ovr_valid", {31'h0, data_valid}, 1);
      ack_pulse();
      idle(8);
      // ack on the completion edge lets the new byte through
      exp_q.push_back(8'h33);
      send_byte(8'h33, CPB, 1'b1);
      exp_q.push_back(8'h44);
      fork
         send_byte(8'h44, CPB, 1'b1);
         begin
            repeat (154) @(posedge clk);
            #1 ack_man = 1'b1;
            @(posedge clk);
            #1 ack_man = 1'b0;
         end
      join
      chk("ack_same_edge_data", {24'h0, data}, 8'h44);
      chk("ack_same_edge_valid", {31'h0, data_valid}, 1);
      chk("ack_same_edge_ovr", ov_cnt, exp_ov);
      ack_pulse();
      idle(8);

      // reset during bit 4
      auto_en = 1'b1;
      exp_q.push_back(8'h01);
      send_byte(8'h01, CPB, 1'b1);
      idle(8);
      fork
         send_byte(8'h77, CPB, 1'b1);
         begin
            repeat (85) @(posedge clk);
            #1 rst_n = 1'b0;
            @(posedge clk);
            #1 rst_n = 1'b1;
            chk("mid_rst_data", {24'h0, data}, 0);
            chk("mid_rst_valid", {31'h0, data_valid}, 0);
            chk("mid_rst_busy", {31'h0, rx_busy}, 0);
            chk("mid_rst_err", {30'h0, frame_err, overrun}, 0);
         end
      join
      // the low bit 7 of the cut frame looks like a fresh start bit over an idle line
      exp_q.push_back(8'hFF);
      idle(320);
      exp_q.push_back(8'h77);
      send_byte(8'h77, CPB, 1'b1);
      idle(32);

      // baud tolerance
      exp_q.push_back(exp_byte(8'h96, 17));
      send_byte(8'h96, 17, 1'b1);
      idle(32);
      chk("slow_data", {24'h0, data}, 8'h96);
      exp_q.push_back(exp_byte(8'h96, 15));
      send_byte(8'h96, 15, 1'b1);
      idle(32);
      chk("fast_data", {24'h0, data}, {24'h0, exp_byte(8'h96, 15)});

      // random traffic
      for (int k = 0; k < 24; k++) begin
         b = 8'($urandom);
         exp_q.push_back(b);
         send_byte(b, CPB, 1'b1);
         idle($urandom_range(0, 20));
      end
      idle(200);
      chk("final_drained", exp_q.size(), 0);
      chk("final_frame_err", fe_cnt, exp_fe);
      chk("final_overrun", ov_cnt, exp_ov);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
